// File: rtl/or1200_vld_pkg.sv
// Shared types and constants for the JPEG VLC bit-unpacking datapath.
// Optional marker detection is enabled with VLD_MARKER_DETECT_EN.
package or1200_vld_pkg;

    typedef enum logic {IDLE, WAIT} op_state_t;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_STOP} fill_state_t;
    typedef enum logic [1:0] {B_KEEP, B_DROP, B_MARKER} byte_cls_t;

    localparam int          BUF_W      = 32;
    localparam int          MAX_GET    = 16;
    localparam logic [7:0]  BYTE_FF    = 8'hFF;
    localparam logic [7:0]  BYTE_STUFF = 8'h00;

    // Top n bits of the buffer, right-justified; n=0 yields zero.
    function automatic logic [BUF_W-1:0] head_bits(input logic [BUF_W-1:0] reg_v,
                                                   input logic [4:0]       n);
        logic [5:0] sh;
        sh = 6'(BUF_W) - {1'b0, n};
        return (n == 5'd0) ? '0 : (reg_v >> sh);
    endfunction

endpackage

// File: rtl/or1200_vld_unstuff.sv
// Byte classifier: tracks a preceding 0xFF and marks each fetched byte keep/drop/marker.
// Marker capture exists only when VLD_MARKER_DETECT_EN is defined.
module or1200_vld_unstuff
    import or1200_vld_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       byte_vld_i,
    input  logic [7:0] byte_i,
    input  logic       clr_i,
    output byte_cls_t  cls_o,
    output logic       marker_o,
    output logic [7:0] marker_code_o
);

    logic ff_seen_q, ff_seen_d;

    always_comb begin
        cls_o = B_KEEP;
        if (ff_seen_q) begin
            if (byte_i == BYTE_STUFF) cls_o = B_DROP;
`ifdef VLD_MARKER_DETECT_EN
            else                      cls_o = B_MARKER;
`endif
        end
    end

    always_comb begin
        ff_seen_d = ff_seen_q;
        if (clr_i)           ff_seen_d = 1'b0;
        else if (byte_vld_i) ff_seen_d = (cls_o == B_KEEP) && (byte_i == BYTE_FF);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ff_seen_q <= 1'b0;
        else       ff_seen_q <= ff_seen_d;
    end

`ifdef VLD_MARKER_DETECT_EN
    logic       marker_q, marker_d;
    logic [7:0] code_q, code_d;

    always_comb begin
        marker_d = marker_q;
        code_d   = code_q;
        if (clr_i) begin
            marker_d = 1'b0;
            code_d   = 8'h00;
        end else if (byte_vld_i && cls_o == B_MARKER) begin
            marker_d = 1'b1;
            code_d   = byte_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            marker_q <= 1'b0;
            code_q   <= 8'h00;
        end else begin
            marker_q <= marker_d;
            code_q   <= code_d;
        end
    end

    assign marker_o      = marker_q;
    assign marker_code_o = code_q;
`else
    assign marker_o      = 1'b0;
    assign marker_code_o = 8'h00;
`endif

endmodule

// File: rtl/or1200_vld_dp.sv
// JPEG VLC bit-unpacking datapath: byte fetch, 0xFF00 unstuffing, MSB-aligned bit buffer, get_bits ops.
// Marker detection (fill stop on FF xx) is enabled with VLD_MARKER_DETECT_EN.
module or1200_vld_dp
    import or1200_vld_pkg::*;
#(
    parameter int FILL_THRESH = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        load_byte_o,
    input  logic        ack_i,
    input  logic [7:0]  byte_i,
    input  logic        get_bits_i,
    input  logic [4:0]  num_bits_i,
    output logic [31:0] bits_o,
    output logic        done_o,
    output logic        busy_o,
    input  logic        spr_addr,
    input  logic        write_dp_spr_i,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o,
    output logic        marker_o,
    output logic [7:0]  marker_code_o
);

    logic [BUF_W-1:0] bit_reg_q, bit_reg_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    op_state_t        op_q, op_d;
    fill_state_t      fill_q, fill_d;
    logic [4:0]       n_q, n_d;
    logic [31:0]      bits_q, bits_d;
    logic             done_q, done_d;

    logic             byte_vld, stopped, consume;
    logic [4:0]       n_req, n_use;
    byte_cls_t        byte_cls;

    assign byte_vld = (fill_q == F_REQ) && ack_i;
    assign stopped  = (fill_q == F_STOP);
    assign n_req    = (num_bits_i > 5'(MAX_GET)) ? 5'(MAX_GET) : num_bits_i;

    or1200_vld_unstuff u_unstuff (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .byte_vld_i    (byte_vld),
        .byte_i        (byte_i),
        .clr_i         (write_dp_spr_i),
        .cls_o         (byte_cls),
        .marker_o      (marker_o),
        .marker_code_o (marker_code_o)
    );

    // Op FSM; once the fill has stopped on a marker, a short buffer is zero-padded.
    always_comb begin
        op_d    = op_q;
        n_d     = n_q;
        n_use   = n_req;
        consume = 1'b0;
        done_d  = 1'b0;
        bits_d  = '0;
        if (write_dp_spr_i) begin
            op_d = IDLE;
        end else begin
            case (op_q)
                IDLE: if (get_bits_i) begin
                    if (bit_cnt_q >= {1'b0, n_req} || stopped) begin
                        consume = 1'b1;
                    end else begin
                        op_d = WAIT;
                        n_d  = n_req;
                    end
                end
                WAIT: begin
                    n_use = n_q;
                    if (bit_cnt_q >= {1'b0, n_q} || stopped) begin
                        consume = 1'b1;
                        op_d    = IDLE;
                    end
                end
                default: op_d = IDLE;
            endcase
        end
        if (consume) begin
            done_d = 1'b1;
            bits_d = head_bits(bit_reg_q, n_use);
        end
    end

    // Consume is applied before append so a same-cycle byte lands behind the remaining bits.
    always_comb begin
        bit_reg_d = bit_reg_q;
        bit_cnt_d = bit_cnt_q;
        if (write_dp_spr_i) begin
            if (spr_addr) bit_reg_d = spr_dat_i;
            else          bit_cnt_d = spr_dat_i[5:0];
        end else if (consume) begin
            bit_reg_d = bit_reg_q << n_use;
            bit_cnt_d = (bit_cnt_q >= {1'b0, n_use}) ? bit_cnt_q - {1'b0, n_use} : 6'd0;
        end
        if (byte_vld && byte_cls == B_KEEP) begin
            bit_reg_d = bit_reg_d | ({byte_i, 24'h000000} >> bit_cnt_d);
            bit_cnt_d = bit_cnt_d + 6'd8;
        end
    end

    always_comb begin
        fill_d = fill_q;
        case (fill_q)
            F_IDLE: if (bit_cnt_q <= 6'(FILL_THRESH)) fill_d = F_REQ;
            F_REQ:  if (ack_i)
                        fill_d = (byte_cls == B_MARKER && !write_dp_spr_i) ? F_STOP : F_IDLE;
            F_STOP: if (write_dp_spr_i) fill_d = F_IDLE;
            default: fill_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_reg_q <= '0;
            bit_cnt_q <= '0;
            op_q      <= IDLE;
            fill_q    <= F_IDLE;
            n_q       <= '0;
            bits_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            bit_reg_q <= bit_reg_d;
            bit_cnt_q <= bit_cnt_d;
            op_q      <= op_d;
            fill_q    <= fill_d;
            n_q       <= n_d;
            bits_q    <= bits_d;
            done_q    <= done_d;
        end
    end

    assign load_byte_o = (fill_q == F_REQ);
    assign busy_o      = (op_q == WAIT);
    assign done_o      = done_q;
    assign bits_o      = bits_q;
    assign spr_dat_o   = spr_addr ? bit_reg_q : {26'b0, bit_cnt_q};

endmodule

// File: tb/tb_or1200_vld_dp.sv
// Self-checking bench for or1200_vld_dp: bit-stream queue model plus directed literal checks.
// Marker-specific expectations are compiled in when VLD_MARKER_DETECT_EN is defined.
module tb_or1200_vld_dp;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_byte_o;
  logic        ack_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        get_bits_i;
  logic [4:0]  num_bits_i;
  logic [31:0] bits_o;
  logic        done_o;
  logic        busy_o;
  logic        spr_addr;
  logic        write_dp_spr_i;
  logic [31:0] spr_dat_i;
  logic [31:0] spr_dat_o;
  logic        marker_o;
  logic [7:0]  marker_code_o;

  or1200_vld_dp dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .load_byte_o    (load_byte_o),
    .ack_i          (ack_i),
    .byte_i         (byte_i),
    .get_bits_i     (get_bits_i),
    .num_bits_i     (num_bits_i),
    .bits_o         (bits_o),
    .done_o         (done_o),
    .busy_o         (busy_o),
    .spr_addr       (spr_addr),
    .write_dp_spr_i (write_dp_spr_i),
    .spr_dat_i      (spr_dat_i),
    .spr_dat_o      (spr_dat_o),
    .marker_o       (marker_o),
    .marker_code_o  (marker_code_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: the decoded stream as a bit queue, pending op widths, stuffing state, marker state.
  bit         model_bits[$];
  int         get_q[$];
  logic [7:0] src_q[$];
  logic       model_ff = 1'b0;
  logic       model_mk = 1'b0;
  logic [7:0] model_code = 8'h00;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Byte source: answers a pending request with the next queued byte.
  always @(negedge clk_i) begin
    if (!rst_i && load_byte_o && src_q.size() > 0) begin
      ack_i  = 1'b1;
      byte_i = src_q.pop_front();
    end else begin
      ack_i  = 1'b0;
      byte_i = 8'h00;
    end
  end

  // Stream model: apply unstuffing rules to every accepted byte.
  always @(posedge clk_i) begin
    if (!rst_i && load_byte_o && ack_i) begin
      if (model_ff && byte_i == 8'h00) begin
        model_ff = 1'b0;
      end
`ifdef VLD_MARKER_DETECT_EN
      else if (model_ff) begin
        model_ff   = 1'b0;
        model_mk   = 1'b1;
        model_code = byte_i;
      end
`endif
      else begin
        for (int i = 7; i >= 0; i--) model_bits.push_back(byte_i[i]);
        model_ff = (byte_i == 8'hFF);
      end
    end
  end

  // Compare process: results at done_o, buffered bit count and marker state every cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) begin
        if (get_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=1 expected no pending op");
        end else begin
          int n;
          logic [31:0] e;
          bit b;
          n = get_q.pop_front();
          e = '0;
          for (int i = 0; i < n; i++) begin
            b = 1'b0;
            if (model_bits.size() > 0) b = model_bits.pop_front();
            e = {e[30:0], b};
          end
          chk("bits_o_model", bits_o, e);
        end
      end
      if (spr_addr == 1'b0 && !write_dp_spr_i)
        chk("bit_cnt_model", spr_dat_o, 32'(model_bits.size()));
      chk("marker_model", {23'b0, marker_o, marker_code_o}, {23'b0, model_mk, model_mk ? model_code : 8'h00});
    end
  end

  task automatic start_get(input int n);
    @(negedge clk_i);
    get_bits_i = 1'b1;
    num_bits_i = 5'(n);
    get_q.push_back(n > 16 ? 16 : n);
    @(posedge clk_i);
    #1;
    get_bits_i = 1'b0;
  endtask

  task automatic pulse_get_ignored(input int n);
    @(negedge clk_i);
    get_bits_i = 1'b1;
    num_bits_i = 5'(n);
    @(negedge clk_i);
    get_bits_i = 1'b0;
  endtask

  task automatic wait_done(input string name, output logic [31:0] got);
    int k;
    got = '0;
    for (k = 0; k < 300; k++) begin
      if (done_o) break;
      @(posedge clk_i);
      #1;
    end
    if (k == 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done_o expected done_o within 300 cycles", name);
    end else begin
      got = bits_o;
    end
  endtask

  task automatic do_get(input string name, input int n, input logic [31:0] exp);
    logic [31:0] got;
    start_get(n);
    wait_done(name, got);
    chk(name, got, exp);
  endtask

  task automatic wait_cnt(input string name, input int v);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (spr_dat_o == 32'(v)) break;
    end
    if (k == 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got bit_cnt=%0d expected %0d", name, spr_dat_o, v);
    end
  endtask

  task automatic spr_write(input logic a, input logic [31:0] d);
    @(negedge clk_i);
    write_dp_spr_i = 1'b1;
    spr_addr       = a;
    spr_dat_i      = d;
    @(posedge clk_i);
    get_q.delete();
    model_ff = 1'b0;
    model_mk = 1'b0;
    if (a == 1'b0) begin
      while (model_bits.size() > int'(d[5:0])) void'(model_bits.pop_back());
      while (model_bits.size() < int'(d[5:0])) model_bits.push_back(1'b0);
    end else begin
      for (int i = 0; i < model_bits.size() && i < 32; i++) model_bits[i] = d[31-i];
    end
    #1;
    write_dp_spr_i = 1'b0;
    spr_addr       = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    int          cnt;

    // Reset state
    rst_i          = 1'b1;
    get_bits_i     = 1'b0;
    num_bits_i     = '0;
    spr_addr       = 1'b0;
    write_dp_spr_i = 1'b0;
    spr_dat_i      = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_load_byte", {31'b0, load_byte_o}, 32'h0);
    chk("rst_done", {31'b0, done_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_bits", bits_o, 32'h0);
    chk("rst_cnt", spr_dat_o, 32'h0);
    chk("rst_marker", {23'b0, marker_o, marker_code_o}, 32'h0);
    spr_addr = 1'b1;
    #1;
    chk("rst_bit_reg", spr_dat_o, 32'h0);
    spr_addr = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Bytes 12 34: get 4 then get 12
    src_q.push_back(8'h12);
    src_q.push_back(8'h34);
    wait_cnt("fill_1234", 16);
    do_get("get4_1234", 4, 32'h1);
    do_get("get12_1234", 12, 32'h234);
    chk("cnt_after_1234", spr_dat_o, 32'h0);

    // Stuffed zero after FF is dropped
    src_q.push_back(8'hFF);
    src_q.push_back(8'h00);
    src_q.push_back(8'hAB);
    wait_cnt("fill_ff00ab", 16);
    do_get("get16_ffab", 16, 32'hFFAB);

    // Empty buffer: stall until two bytes arrive; a get while busy is ignored
    start_get(16);
    repeat (3) @(negedge clk_i);
    chk("busy_wait", {31'b0, busy_o}, 32'h1);
    pulse_get_ignored(4);
    src_q.push_back(8'h5A);
    src_q.push_back(8'hC3);
    wait_done("get16_wait", got);
    chk("get16_wait", got, 32'h5AC3);
    repeat (6) @(negedge clk_i);

    // SPR write aborts WAIT without done_o
    start_get(16);
    repeat (3) @(negedge clk_i);
    chk("busy_before_abort", {31'b0, busy_o}, 32'h1);
    spr_write(1'b0, 32'd5);
    @(negedge clk_i);
    chk("busy_after_abort", {31'b0, busy_o}, 32'h0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (done_o) cnt++;
    end
    chk("no_done_after_abort", 32'(cnt), 32'h0);
    chk("cnt_after_abort", spr_dat_o, 32'd5);

    // Zero-width get
    do_get("get0", 0, 32'h0);
    chk("cnt_after_get0", spr_dat_o, 32'd5);

    // SPR load of buffer, clamped width
    spr_write(1'b0, 32'd32);
    spr_write(1'b1, 32'hDEADBEEF);
    @(negedge clk_i);
    spr_addr = 1'b1;
    #1;
    chk("spr_bit_reg", spr_dat_o, 32'hDEADBEEF);
    spr_addr = 1'b0;
    do_get("get20_clamp", 20, 32'hDEAD);
    do_get("get16_beef", 16, 32'hBEEF);
    chk("cnt_after_beef", spr_dat_o, 32'h0);

    // FF followed by a non-zero byte
    src_q.push_back(8'hFF);
    src_q.push_back(8'hD9);
`ifdef VLD_MARKER_DETECT_EN
    cnt = 0;
    while (!marker_o && cnt < 300) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("marker_set", {31'b0, marker_o}, 32'h1);
    chk("marker_code", {24'b0, marker_code_o}, 32'hD9);
    cnt = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (load_byte_o) cnt++;
    end
    chk("fill_stopped", 32'(cnt), 32'h0);
    do_get("get16_padded", 16, 32'hFF00);
    spr_write(1'b0, 32'd0);
    @(negedge clk_i);
    chk("marker_cleared", {31'b0, marker_o}, 32'h0);
`else
    wait_cnt("fill_ffd9", 16);
    do_get("get16_ffd9", 16, 32'hFFD9);
    chk("marker_tied", {23'b0, marker_o, marker_code_o}, 32'h0);
`endif

    // Mixed stream with fetch and consume overlapping
    src_q = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h7E, 8'h01, 8'hC4, 8'h99, 8'h10, 8'hEF};
    do_get("mix_get3", 3, 32'h5);
    start_get(7);  wait_done("mix_get7", got);
    start_get(1);  wait_done("mix_get1", got);
    start_get(16); wait_done("mix_get16a", got);
    start_get(5);  wait_done("mix_get5", got);
    start_get(9);  wait_done("mix_get9", got);
    start_get(13); wait_done("mix_get13", got);
    start_get(2);  wait_done("mix_get2", got);
    do_get("mix_get16b", 16, 32'h10EF);
    wait_cnt("mix_drained", 0);

    // Asynchronous reset drops a pending fetch request immediately
    chk("req_before_rst", {31'b0, load_byte_o}, 32'h1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("req_async_rst", {31'b0, load_byte_o}, 32'h0);
    chk("cnt_async_rst", spr_dat_o, 32'h0);
    model_bits.delete();
    get_q.delete();
    model_ff = 1'b0;
    model_mk = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
